rgb_sram_streamer: RTL and testbench
====================================

Name: rgb_sram_streamer

Overview:
- Downstream neighbour of the YUV-to-RGB colourspace stage.
- Reads the packed RGB frame that stage wrote to external SRAM, starting at RGB_OFFSET.
- Unpacks each 3-word group into two 24-bit pixels and streams them in raster order over a valid/ready interface to the display/export path.
- Decouples SRAM read latency from downstream backpressure with a small credit-controlled word FIFO.

Parameters:
- RGB_OFFSET, 146944, SRAM word address of the first packed RGB word.
- IMG_WIDTH, 320, pixels per row; must be even.
- IMG_HEIGHT, 240, rows per frame.
- FIFO_DEPTH, 8, word FIFO entries; power of two, at least 4.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame read when idle.
- done  out  1  one-cycle pulse after the final pixel handshake.
- SRAM_address  out  18  registered read address.
- SRAM_we_n  out  1  constant 1; this block never writes.
- SRAM_read_data  in  16  SRAM read data.
- pix_valid  out  1  output pixel valid.
- pix_ready  in  1  downstream accept.
- pix_r  out  8  red component.
- pix_g  out  8  green component.
- pix_b  out  8  blue component.
- pix_x  out  9  column of the current pixel, 0..IMG_WIDTH-1.
- pix_y  out  8  row of the current pixel, 0..IMG_HEIGHT-1.
- pix_eol  out  1  high with the pixel where pix_x == IMG_WIDTH-1.

Behaviour:
- Reset values: SRAM_address=0, SRAM_we_n=1, done=0, pix_valid=0, pix_r/g/b=0, pix_x=0, pix_y=0, pix_eol=0.
  - FIFO is emptied, in-flight read count cleared, FSM goes to IDLE.
  - Applies identically mid-frame: data returning from already-issued reads is discarded.
- Packing: words k, k+1, k+2 (k a multiple of 3) are {R0,G0}, {B0,R1}, {G1,B1}, upper byte first.
  - Frame length NW = IMG_WIDTH*IMG_HEIGHT*3/2 words; 115200 at defaults, last address 262143.
- SRAM timing: address registered in cycle N; its data is sampled from SRAM_read_data in cycle N+2. A 2-stage valid shift register tracks reads in flight.
- FSM states:
  - IDLE: on start, clear word index, x and y; go to READ. A start pulse in any other state is ignored.
  - READ: each cycle, issue address RGB_OFFSET+word_idx and increment word_idx only when fifo_count + inflight < FIFO_DEPTH. After issuing word NW-1, go to DRAIN.
  - DRAIN: no further reads. Go to DONE on the handshake of pixel (IMG_WIDTH-1, IMG_HEIGHT-1).
  - DONE: done=1 for exactly one cycle, then IDLE.
- FIFO:
  - Write when the delayed read-valid is high; pop when the unpacker needs a word.
  - Simultaneous push and pop leaves the count unchanged.
  - Credit rule makes overflow impossible; an overflow is a verification assertion failure.
- Unpacker:
  - 3-word triplet register; pops words while the triplet is incomplete.
  - With a full triplet, presents pixel 0, then pixel 1, then frees the triplet.
  - The next triplet may be filled while pixel 1 is held.
- Output handshake:
  - Transfer occurs when pix_valid && pix_ready.
  - While pix_valid && !pix_ready, pix_r/g/b/x/y/eol are held stable.
  - pix_valid never drops without a transfer.
- Coordinates: after each transfer pix_x increments; at IMG_WIDTH-1 it wraps to 0 and pix_y increments. pix_y reaching IMG_HEIGHT-1 ends the frame; no wrap beyond it.
- Throughput with pix_ready held high: 2 pixels per 3 cycles sustained. First pix_valid no later than 8 cycles after start.
- Arithmetic: word_idx is 17 bits. Address sum is 18 bits unsigned; it must not overflow at default parameters.

Test Plan:
- Frame content check:
  - Stimulus: IMG_WIDTH=4, IMG_HEIGHT=2; SRAM words 0..11 preloaded; first three are 0x1122, 0x3344, 0x5566; pix_ready=1.
  - Required: pixel (0,0)=R11 G22 B33; pixel (1,0)=R44 G55 B66; 8 pixels total, in order; pix_eol on x=3; done pulses once.
- Backpressure:
  - Stimulus: pix_ready low for 20 cycles after the first pix_valid.
  - Required: outputs stable throughout; inflight+fifo_count never exceeds FIFO_DEPTH; no pixel lost or duplicated after ready returns.
- Random ready:
  - Stimulus: default 320x240 frame with 50% random pix_ready.
  - Required: 76800 pixels with correct x/y sequence; last read address 262143; done exactly once.
- Reset mid-frame:
  - Stimulus: assert reset for 1 cycle at pixel 100, then start again.
  - Required: all outputs at reset values the cycle after; new frame restarts at address 146944 with pixel (0,0).
- Start while busy:
  - Stimulus: pulse start at pixel 5 of a running frame.
  - Required: ignored; address sequence uninterrupted; single done.
- SRAM_we_n:
  - Stimulus: any of the above runs.
  - Required: SRAM_we_n is 1 in every cycle.

Source files
------------

// File: rtl/rgb_sram_streamer.sv
// Reads a packed RGB frame from external SRAM and streams it as 24-bit pixels
// in raster order over a valid/ready interface, using a credit-controlled word FIFO.
module rgb_sram_streamer #(
  parameter int unsigned RGB_OFFSET = 146944,
  parameter int unsigned IMG_WIDTH  = 320,
  parameter int unsigned IMG_HEIGHT = 240,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b,
  output logic [8:0]  pix_x,
  output logic [7:0]  pix_y,
  output logic        pix_eol
);

  localparam int unsigned NUM_WORDS = IMG_WIDTH * IMG_HEIGHT * 3 / 2;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned AW        = 18;
  localparam int unsigned IDX_W     = 17;
  localparam int unsigned XW        = 9;
  localparam int unsigned YW        = 8;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   word_idx_q, word_idx_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [1:0]         rd_vld_q, rd_vld_d;
  logic [15:0]        fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [2:0][15:0]   trip_q, trip_d;
  logic [1:0]         trip_cnt_q, trip_cnt_d;
  logic               p1_pend_q, p1_pend_d;
  logic [23:0]        p1_q, p1_d;
  logic [XW-1:0]      nx_q, nx_d;
  logic [YW-1:0]      ny_q, ny_d;
  logic               pix_valid_q, pix_valid_d;
  logic [23:0]        rgb_q, rgb_d;
  logic [XW-1:0]      pix_x_q, pix_x_d;
  logic [YW-1:0]      pix_y_q, pix_y_d;
  logic               pix_eol_q, pix_eol_d;
  logic               done_q, done_d;

  logic [CNT_W-1:0]   inflight;
  logic [1:0]         trip_cnt_eff;
  logic               issue, push, pop, load, trip_free, out_free, last_hs;

  // Next-state, read issue, FIFO bookkeeping, unpacker and output register.
  always_comb begin
    state_d      = state_q;
    word_idx_d   = word_idx_q;
    addr_d       = addr_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    trip_d       = trip_q;
    p1_pend_d    = p1_pend_q;
    p1_d         = p1_q;
    nx_d         = nx_q;
    ny_d         = ny_q;
    pix_valid_d  = pix_valid_q;
    rgb_d        = rgb_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_eol_d    = pix_eol_q;
    load         = 1'b0;
    trip_free    = 1'b0;

    inflight = CNT_W'(rd_vld_q[0]) + CNT_W'(rd_vld_q[1]);
    issue    = (state_q == S_READ) && ((fifo_cnt_q + inflight) < CNT_W'(FIFO_DEPTH));
    rd_vld_d = {rd_vld_q[0], issue};
    push     = rd_vld_q[1];
    out_free = !pix_valid_q || pix_ready;
    last_hs  = pix_valid_q && pix_ready && (pix_x_q == XW'(IMG_WIDTH - 1))
               && (pix_y_q == YW'(IMG_HEIGHT - 1));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_READ;
          word_idx_d = '0;
          nx_d       = '0;
          ny_d       = '0;
        end
      end
      S_READ: begin
        if (issue) begin
          addr_d     = AW'(RGB_OFFSET) + AW'(word_idx_q);
          word_idx_d = word_idx_q + IDX_W'(1);
          if (word_idx_q == IDX_W'(NUM_WORDS - 1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (last_hs) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_DONE);

    if (pix_valid_q && pix_ready) pix_valid_d = 1'b0;

    // Pixel 1 is parked in p1 so the triplet can refill while it waits.
    if (out_free) begin
      if (p1_pend_q) begin
        load      = 1'b1;
        rgb_d     = p1_q;
        p1_pend_d = 1'b0;
      end else if (trip_cnt_q == 2'd3) begin
        load      = 1'b1;
        rgb_d     = {trip_q[0], trip_q[1][15:8]};
        p1_d      = {trip_q[1][7:0], trip_q[2]};
        p1_pend_d = 1'b1;
        trip_free = 1'b1;
      end
    end

    if (load) begin
      pix_valid_d = 1'b1;
      pix_x_d     = nx_q;
      pix_y_d     = ny_q;
      pix_eol_d   = (nx_q == XW'(IMG_WIDTH - 1));
      if (nx_q == XW'(IMG_WIDTH - 1)) begin
        nx_d = '0;
        if (ny_q != YW'(IMG_HEIGHT - 1)) ny_d = ny_q + YW'(1);
      end else begin
        nx_d = nx_q + XW'(1);
      end
    end

    trip_cnt_eff = trip_free ? 2'd0 : trip_cnt_q;
    pop          = (fifo_cnt_q != '0) && (trip_cnt_eff != 2'd3);
    trip_cnt_d   = trip_cnt_eff;
    if (pop) begin
      case (trip_cnt_eff)
        2'd0:    trip_d[0] = fifo_mem_q[rd_ptr_q];
        2'd1:    trip_d[1] = fifo_mem_q[rd_ptr_q];
        default: trip_d[2] = fifo_mem_q[rd_ptr_q];
      endcase
      trip_cnt_d = trip_cnt_eff + 2'd1;
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
    end
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      word_idx_q  <= '0;
      addr_q      <= '0;
      rd_vld_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      trip_q      <= '0;
      trip_cnt_q  <= '0;
      p1_pend_q   <= 1'b0;
      p1_q        <= '0;
      nx_q        <= '0;
      ny_q        <= '0;
      pix_valid_q <= 1'b0;
      rgb_q       <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_eol_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      addr_q      <= addr_d;
      rd_vld_q    <= rd_vld_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      trip_q      <= trip_d;
      trip_cnt_q  <= trip_cnt_d;
      p1_pend_q   <= p1_pend_d;
      p1_q        <= p1_d;
      nx_q        <= nx_d;
      ny_q        <= ny_d;
      pix_valid_q <= pix_valid_d;
      rgb_q       <= rgb_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_eol_q   <= pix_eol_d;
      done_q      <= done_d;
    end
  end

  // Storage only; occupancy and pointers live in the reset domain above.
  always_ff @(posedge clock) begin
    if (push) fifo_mem_q[wr_ptr_q] <= SRAM_read_data;
  end

  assign SRAM_address = addr_q;
  assign SRAM_we_n    = 1'b1;
  assign done         = done_q;
  assign pix_valid    = pix_valid_q;
  assign pix_r        = rgb_q[23:16];
  assign pix_g        = rgb_q[15:8];
  assign pix_b        = rgb_q[7:0];
  assign pix_x        = pix_x_q;
  assign pix_y        = pix_y_q;
  assign pix_eol      = pix_eol_q;

endmodule

// File: tb/tb_rgb_sram_streamer.sv
// Scoreboard bench for rgb_sram_streamer: a byte-stream model of the frame feeds
// expected pixels and addresses; a monitor checks handshakes, stability and done.
module tb_rgb_sram_streamer;

  localparam int unsigned W      = 16;
  localparam int unsigned H      = 8;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned NPIX   = W * H;
  localparam int unsigned NW     = NPIX * 3 / 2;
  localparam int unsigned OFFSET = 262144 - NW;

  logic        clock, reset, start, done;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;
  logic        pix_valid, pix_ready;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic [8:0]  pix_x;
  logic [7:0]  pix_y;
  logic        pix_eol;

  rgb_sram_streamer #(
    .RGB_OFFSET(OFFSET), .IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .done(done),
    .SRAM_address(SRAM_address), .SRAM_we_n(SRAM_we_n),
    .SRAM_read_data(SRAM_read_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pix_x(pix_x), .pix_y(pix_y), .pix_eol(pix_eol)
  );

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [8:0] x;
    logic [7:0] y;
    logic       eol;
  } pix_t;

  pix_t        exp_q[$];
  logic [17:0] exp_addr_q[$];
  logic [15:0] mem [NW];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          hs_cnt   = 0;
  int          done_cnt = 0;
  int          cyc      = 0;
  int          first_hs = -1;
  int          last_hs  = 0;
  logic [17:0] last_addr = '0;
  int          rdy_mode = 0;
  int          stall_left = 0;
  bit          stall_armed = 0;
  bit          prev_stall = 0;
  pix_t        prev_pix;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Sync SRAM: data for the address seen at one edge is on the bus after the next.
  always @(posedge clock) begin
    if (SRAM_address >= 18'(OFFSET) && int'(SRAM_address) < int'(OFFSET + NW))
      SRAM_read_data <= mem[int'(SRAM_address) - int'(OFFSET)];
    else
      SRAM_read_data <= 16'h0000;
  end

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // The frame is a byte stream R0 G0 B0 R1 G1 B1 ... packed two bytes per word, high first.
  function automatic logic [7:0] byte_at(input int i);
    logic [15:0] w;
    w = mem[i / 2];
    return (i % 2 == 0) ? w[15:8] : w[7:0];
  endfunction

  function automatic pix_t ref_pix(input int p);
    pix_t e;
    e.r   = byte_at(3 * p);
    e.g   = byte_at(3 * p + 1);
    e.b   = byte_at(3 * p + 2);
    e.x   = 9'(p % W);
    e.y   = 8'(p / W);
    e.eol = (p % W) == (W - 1);
    return e;
  endfunction

  function automatic pix_t cur_pix();
    pix_t c;
    c.r = pix_r; c.g = pix_g; c.b = pix_b;
    c.x = pix_x; c.y = pix_y; c.eol = pix_eol;
    return c;
  endfunction

  task automatic start_frame();
    exp_q.delete();
    exp_addr_q.delete();
    for (int p = 0; p < int'(NPIX); p++) exp_q.push_back(ref_pix(p));
    for (int k = 0; k < int'(NW); k++) exp_addr_q.push_back(18'(OFFSET + k));
    hs_cnt   = 0;
    done_cnt = 0;
    first_hs = -1;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic wait_hs(input int n, input int budget);
    int i = 0;
    while (hs_cnt < n && i < budget) begin @(posedge clock); i++; end
    chk(hs_cnt >= n, "handshake_timeout", hs_cnt, n);
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (done_cnt == 0 && i < budget) begin @(posedge clock); i++; end
    chk(done_cnt != 0, "done_timeout", done_cnt, 1);
  endtask

  task automatic end_of_frame();
    repeat (5) @(posedge clock);
    chk(done_cnt == 1, "done_count", done_cnt, 1);
    chk(hs_cnt == int'(NPIX), "pixel_count", hs_cnt, NPIX);
    chk(exp_q.size() == 0, "pixels_left", exp_q.size(), 0);
    chk(exp_addr_q.size() == 0, "addrs_left", exp_addr_q.size(), 0);
    chk(last_addr == 18'(OFFSET + NW - 1), "last_addr", last_addr, OFFSET + NW - 1);
  endtask

  task automatic check_reset_values(input string name);
    logic [63:0] v;
    v = {done, SRAM_address, pix_valid, pix_r, pix_g, pix_b, pix_x, pix_y, pix_eol};
    chk(v == 64'd0, name, v, 0);
  endtask

  task automatic randomize_mem();
    for (int k = 0; k < int'(NW); k++) mem[k] = 16'($urandom);
  endtask

  // Ready driver: 0 always high, 1 random, 2 held low 20 cycles after first valid.
  initial forever begin
    @(posedge clock); #1;
    case (rdy_mode)
      1: pix_ready = 1'($urandom_range(0, 1));
      2: begin
        if (!stall_armed && pix_valid) begin
          stall_armed = 1'b1;
          stall_left  = 20;
        end
        if (stall_armed && stall_left > 0) begin
          pix_ready = 1'b0;
          stall_left--;
        end else begin
          pix_ready = 1'b1;
        end
      end
      default: pix_ready = 1'b1;
    endcase
  end

  // Monitor: scoreboard pops on handshakes and address changes; hold and credit checks.
  initial forever begin
    int   occ;
    pix_t c;
    pix_t e;
    @(negedge clock);
    c = cur_pix();
    chk(SRAM_we_n === 1'b1, "we_n", SRAM_we_n, 1);
    occ = int'(dut.fifo_cnt_q) + int'(dut.rd_vld_q[0]) + int'(dut.rd_vld_q[1]);
    chk(occ <= int'(DEPTH), "fifo_credit", occ, DEPTH);
    if (prev_stall)
      chk(pix_valid && c == prev_pix, "hold_stable", {pix_valid, c}, {1'b1, prev_pix});
    prev_stall = !reset && pix_valid && !pix_ready;
    prev_pix   = c;
    if (pix_valid && pix_ready) begin
      hs_cnt++;
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
      if (exp_q.size() == 0) begin
        chk(1'b0, "extra_pixel", c, 0);
      end else begin
        e = exp_q.pop_front();
        chk(c == e, "pixel", c, e);
      end
    end
    if (done) begin
      done_cnt++;
      chk(exp_q.size() == 0, "done_before_last_pixel", exp_q.size(), 0);
    end
    if (SRAM_address !== last_addr) begin
      last_addr = SRAM_address;
      if (SRAM_address != 18'd0) begin
        if (exp_addr_q.size() == 0) chk(1'b0, "extra_address", SRAM_address, 0);
        else begin
          logic [17:0] ea;
          ea = exp_addr_q.pop_front();
          chk(SRAM_address == ea, "address", SRAM_address, ea);
        end
      end
    end
  end

  initial begin
    int lat;
    randomize_mem();
    mem[0] = 16'h1122;
    mem[1] = 16'h3344;
    mem[2] = 16'h5566;
    reset = 1'b1;
    start = 1'b0;
    pix_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_reset_values("reset_values");

    // Full-rate frame: known first group, latency and sustained throughput.
    rdy_mode = 0;
    start_frame();
    lat = 0;
    do begin @(negedge clock); lat++; end while (!pix_valid && lat < 12);
    chk(pix_valid && lat <= 8, "first_valid_latency", lat, 8);
    chk({pix_r, pix_g, pix_b} == 24'h112233, "first_pixel_rgb", {pix_r, pix_g, pix_b}, 24'h112233);
    wait_done(2000);
    chk(last_hs - first_hs <= int'(NPIX * 3 / 2), "throughput_cycles",
        last_hs - first_hs, NPIX * 3 / 2);
    end_of_frame();

    // Backpressure right after the first valid.
    randomize_mem();
    stall_armed = 1'b0;
    rdy_mode = 2;
    start_frame();
    wait_done(3000);
    end_of_frame();

    // Random ready with a start pulse while busy.
    randomize_mem();
    rdy_mode = 1;
    start_frame();
    wait_hs(5, 2000);
    #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    wait_done(4000);
    end_of_frame();

    // Reset mid-frame at pixel 100, then a fresh frame.
    randomize_mem();
    start_frame();
    wait_hs(100, 4000);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    @(negedge clock);
    check_reset_values("reset_midframe_values");
    chk(done_cnt == 0, "no_done_after_reset", done_cnt, 0);
    repeat (10) @(posedge clock);
    chk(pix_valid == 1'b0, "no_stale_pixels", pix_valid, 0);

    randomize_mem();
    start_frame();
    wait_done(4000);
    end_of_frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
